turbo_cb_scheduler: RTL and testbench

- Sequences decoding of a multi-codeblock transport block through the single turbo decoder core (Modu_Decoder_New_CRC).
- Walks codeblock index 0..cb_last and drives the core's start pulse, run enable and RAM page select (dec_cnt) for each block.
- Collects per-codeblock CRC results and guards every decode with a watchdog.
- Sits between the PCIe channel state machine (which issues a start and waits for done) and the decoder core.

---
 rtl/turbo_cb_scheduler_pkg.sv | 16 +
 rtl/turbo_cb_scheduler_watchdog.sv | 42 ++++
 rtl/turbo_cb_scheduler.sv | 133 +++++++++++++
 tb/tb_turbo_cb_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_cb_scheduler_pkg.sv
// Shared definitions for the turbo codeblock scheduler: codeblock index
// width, scheduler state encodings and the default watchdog limit.
package turbo_cb_scheduler_pkg;

    localparam int          CODEBLOCK_AW = 5;
    localparam logic [19:0] TIMEOUT_DEF  = 20'd800000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } sched_state_e;

endpackage

// File: rtl/turbo_cb_scheduler_watchdog.sv
// Per-codeblock watchdog: cleared when a decode starts, counts while the
// core runs, and flags the last allowed cycle while counting.
module turbo_watchdog
    import turbo_cb_scheduler_pkg::*;
#(
    parameter int                   TIMEOUT_W   = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(TIMEOUT_DEF)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_W-1:0] LAST_CYC = TIMEOUT_CYC - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    // Clear has priority so a fresh block always starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i && (cnt_q == LAST_CYC);

endmodule

// File: rtl/turbo_cb_scheduler.sv
// Walks codeblocks 0..cb_last through the single turbo decoder core,
// pulsing its start, holding run high while it decodes, collecting CRC
// results and aborting a block that exceeds the watchdog limit.
module turbo_cb_scheduler
    import turbo_cb_scheduler_pkg::*;
#(
    parameter int                   CB_AW       = CODEBLOCK_AW,
    parameter int                   TIMEOUT_W   = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(TIMEOUT_DEF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sched_start,
    input  logic                    sched_abort,
    input  logic [CB_AW-1:0]        cb_last,
    output logic                    dec_run,
    output logic                    dec_start,
    input  logic                    dec_end,
    input  logic                    dec_crc,
    output logic [CB_AW-1:0]        cb_idx,
    output logic                    sched_busy,
    output logic                    sched_done,
    output logic                    sched_err,
    output logic [CB_AW:0]          crc_fail_cnt,
    output logic [(2**CB_AW)-1:0]   crc_map
);

    sched_state_e            state_q;
    logic [CB_AW-1:0]        cb_last_q;
    logic [CB_AW-1:0]        cb_idx_q;
    logic [CB_AW:0]          crc_fail_cnt_q;
    logic [(2**CB_AW)-1:0]   crc_map_q;
    logic                    dec_run_q;
    logic                    dec_start_q;
    logic                    sched_done_q;
    logic                    sched_err_q;
    logic                    wd_expire;

    turbo_watchdog #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q == ST_START),
        .enable_i (state_q == ST_WAIT),
        .expire_o (wd_expire)
    );

    // Scheduler FSM with registered core controls; abort beats everything,
    // and a dec_end in the expiry cycle is accepted rather than flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cb_last_q      <= '0;
            cb_idx_q       <= '0;
            crc_fail_cnt_q <= '0;
            crc_map_q      <= '0;
            dec_run_q      <= 1'b0;
            dec_start_q    <= 1'b0;
            sched_done_q   <= 1'b0;
            sched_err_q    <= 1'b0;
        end else begin
            dec_start_q  <= 1'b0;
            sched_done_q <= 1'b0;
            if (sched_abort) begin
                state_q   <= ST_IDLE;
                dec_run_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sched_start) begin
                            cb_last_q      <= cb_last;
                            cb_idx_q       <= '0;
                            crc_fail_cnt_q <= '0;
                            crc_map_q      <= '0;
                            sched_err_q    <= 1'b0;
                            dec_start_q    <= 1'b1;
                            dec_run_q      <= 1'b1;
                            state_q        <= ST_START;
                        end
                    end
                    ST_START: begin
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (dec_end) begin
                            crc_map_q[cb_idx_q] <= dec_crc;
                            if (!dec_crc) begin
                                crc_fail_cnt_q <= crc_fail_cnt_q + (CB_AW+1)'(1);
                            end
                            dec_run_q <= 1'b0;
                            state_q   <= ST_GAP;
                        end else if (wd_expire) begin
                            sched_err_q  <= 1'b1;
                            sched_done_q <= 1'b1;
                            dec_run_q    <= 1'b0;
                            state_q      <= ST_FIN;
                        end
                    end
                    ST_GAP: begin
                        if (cb_idx_q == cb_last_q) begin
                            sched_done_q <= 1'b1;
                            state_q      <= ST_FIN;
                        end else begin
                            cb_idx_q    <= cb_idx_q + CB_AW'(1);
                            dec_start_q <= 1'b1;
                            dec_run_q   <= 1'b1;
                            state_q     <= ST_START;
                        end
                    end
                    ST_FIN: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        dec_run_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign dec_run      = dec_run_q;
    assign dec_start    = dec_start_q;
    assign cb_idx       = cb_idx_q;
    assign sched_busy   = (state_q != ST_IDLE);
    assign sched_done   = sched_done_q;
    assign sched_err    = sched_err_q;
    assign crc_fail_cnt = crc_fail_cnt_q;
    assign crc_map      = crc_map_q;

endmodule

// File: tb/tb_turbo_cb_scheduler.sv
// Self-checking bench for turbo_cb_scheduler. A timeline model predicts,
// from per-block decode latencies and CRCs, when each dec_start, dec_run
// window and sched_done occurs, and the final CRC map/fail count/error.
module tb_turbo_cb_scheduler;

    localparam int TC = 150;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sched_start;
    logic       sched_abort;
    logic [2:0] cb_last;
    logic       dec_run;
    logic       dec_start;
    logic       dec_end;
    logic       dec_crc;
    logic [2:0] cb_idx;
    logic       sched_busy;
    logic       sched_done;
    logic       sched_err;
    logic [3:0] crc_fail_cnt;
    logic [7:0] crc_map;

    int vectors = 0;
    int fails   = 0;
    int dly_a[8];
    bit crc_a[8];

    turbo_cb_scheduler #(
        .CB_AW       (3),
        .TIMEOUT_W   (12),
        .TIMEOUT_CYC (12'd150)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sched_start  (sched_start),
        .sched_abort  (sched_abort),
        .cb_last      (cb_last),
        .dec_run      (dec_run),
        .dec_start    (dec_start),
        .dec_end      (dec_end),
        .dec_crc      (dec_crc),
        .cb_idx       (cb_idx),
        .sched_busy   (sched_busy),
        .sched_done   (sched_done),
        .sched_err    (sched_err),
        .crc_fail_cnt (crc_fail_cnt),
        .crc_map      (crc_map)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".dec_run"},   32'(dec_run), 0);
        chk({tag, ".dec_start"}, 32'(dec_start), 0);
        chk({tag, ".busy"},      32'(sched_busy), 0);
        chk({tag, ".done"},      32'(sched_done), 0);
        chk({tag, ".err"},       32'(sched_err), 0);
        chk({tag, ".cb_idx"},    32'(cb_idx), 0);
        chk({tag, ".fail_cnt"},  32'(crc_fail_cnt), 0);
        chk({tag, ".crc_map"},   32'(crc_map), 0);
    endtask

    // Runs one transport block of nblk codeblocks using dly_a/crc_a as the
    // core's behaviour. abort_t > 0 raises sched_abort during that cycle.
    // Cycle t is the t-th falling edge after the one that raised sched_start.
    task automatic run_seq(input string tag, input int nblk, input int abort_t);
        int         s[8];
        int         e[8];
        bit         acc[8];
        int         nst;
        int         done_t;
        int         t0;
        int         fail;
        int         idx_exp;
        int         last_t;
        bit         err;
        bit         stop;
        bit         aborted;
        bit         live;
        bit         x_start;
        bit         x_run;
        bit         x_end;
        bit         x_crc;
        int         kcur;
        logic [7:0] map;

        // Timeline model
        nst = 0; err = 1'b0; stop = 1'b0; map = '0; fail = 0; t0 = 1; done_t = 0;
        for (int k = 0; k < nblk; k++) begin
            if (!stop) begin
                s[k] = t0;
                nst  = k + 1;
                if (dly_a[k] > TC) begin
                    acc[k] = 1'b0;
                    e[k]   = t0 + TC;
                    done_t = e[k] + 1;
                    err    = 1'b1;
                    stop   = 1'b1;
                end else begin
                    acc[k] = 1'b1;
                    e[k]   = t0 + dly_a[k];
                    t0     = e[k] + 2;
                    done_t = e[k] + 2;
                end
            end
        end
        aborted = (abort_t > 0) && (abort_t < done_t);
        idx_exp = nst - 1;
        if (aborted) begin
            err = 1'b0;
            for (int k = 0; k < nst; k++) begin
                if (s[k] <= abort_t) idx_exp = k;
            end
        end
        for (int k = 0; k < nst; k++) begin
            if (acc[k] && (!aborted || e[k] < abort_t)) begin
                map[k] = crc_a[k];
                if (!crc_a[k]) fail++;
            end
        end
        last_t = aborted ? abort_t + 4 : done_t + 2;

        sched_start = 1'b1;
        sched_abort = 1'b0;
        cb_last     = 3'(nblk - 1);
        dec_end     = 1'b0;
        for (int t = 1; t <= last_t; t++) begin
            @(negedge clk);
            live    = !aborted || (t <= abort_t);
            x_start = 1'b0; x_run = 1'b0; x_end = 1'b0; x_crc = 1'b0; kcur = -1;
            for (int k = 0; k < nst; k++) begin
                if (live && t == s[k]) x_start = 1'b1;
                if (live && t >= s[k] && t <= e[k]) begin
                    x_run = 1'b1;
                    kcur  = k;
                end
                if (live && acc[k] && t == e[k]) begin
                    x_end = 1'b1;
                    x_crc = crc_a[k];
                end
            end
            chk({tag, ".dec_start"}, 32'(dec_start), 32'(x_start));
            chk({tag, ".dec_run"},   32'(dec_run), 32'(x_run));
            chk({tag, ".busy"},      32'(sched_busy), 32'(live && t <= done_t));
            chk({tag, ".done"},      32'(sched_done), 32'(live && t == done_t));
            if (kcur >= 0) chk({tag, ".cb_idx"}, 32'(cb_idx), 32'(kcur));
            if (!aborted && t == done_t) begin
                chk({tag, ".err"},      32'(sched_err), 32'(err));
                chk({tag, ".crc_map"},  32'(crc_map), 32'(map));
                chk({tag, ".fail_cnt"}, 32'(crc_fail_cnt), 32'(fail));
            end
            // Inputs for cycle t: stray starts/ends that must be ignored
            sched_start = live && (t < done_t) && ($urandom_range(0, 5) == 0);
            cb_last     = 3'($urandom);
            sched_abort = (t == abort_t);
            if (x_end) begin
                dec_end = 1'b1;
                dec_crc = x_crc;
            end else begin
                dec_end = live && (x_start || t == done_t) && ($urandom_range(0, 1) == 1);
                dec_crc = 1'($urandom);
            end
        end
        sched_start = 1'b0;
        sched_abort = 1'b0;
        dec_end     = 1'b0;
        @(negedge clk);
        chk({tag, ".end_busy"},     32'(sched_busy), 0);
        chk({tag, ".end_cb_idx"},   32'(cb_idx), 32'(idx_exp));
        chk({tag, ".end_crc_map"},  32'(crc_map), 32'(map));
        chk({tag, ".end_fail_cnt"}, 32'(crc_fail_cnt), 32'(fail));
        chk({tag, ".end_err"},      32'(sched_err), 32'(err));
    endtask

    initial begin
        rst_n       = 1'b0;
        sched_start = 1'b0;
        sched_abort = 1'b0;
        cb_last     = '0;
        dec_end     = 1'b0;
        dec_crc     = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Three blocks, 100-cycle decodes, CRC 1,0,1
        dly_a[0] = 100; dly_a[1] = 100; dly_a[2] = 100;
        crc_a[0] = 1;   crc_a[1] = 0;   crc_a[2] = 1;
        run_seq("three_blk", 3, 0);

        // Single block
        dly_a[0] = 5; crc_a[0] = 1;
        run_seq("single_blk", 1, 0);

        // Core never finishes block 0: watchdog abort
        dly_a[0] = 10000; dly_a[1] = 4; crc_a[0] = 1; crc_a[1] = 1;
        run_seq("timeout", 2, 0);
        // Next start clears the error
        dly_a[0] = 3; crc_a[0] = 1;
        run_seq("after_timeout", 1, 0);

        // dec_end exactly in the watchdog's last cycle is accepted
        dly_a[0] = TC; dly_a[1] = 4; crc_a[0] = 0; crc_a[1] = 1;
        run_seq("end_at_expiry", 2, 0);

        // Eight blocks all failing CRC: fail count reaches 2**CB_AW
        for (int k = 0; k < 8; k++) begin
            dly_a[k] = 1 + k;
            crc_a[k] = 0;
        end
        run_seq("all_fail", 8, 0);

        // Abort during block 1 of four, then a clean restart
        dly_a[0] = 6; dly_a[1] = 20; dly_a[2] = 6; dly_a[3] = 6;
        crc_a[0] = 1; crc_a[1] = 0;  crc_a[2] = 1; crc_a[3] = 1;
        run_seq("abort", 4, 14);
        dly_a[0] = 4; dly_a[1] = 4; crc_a[0] = 0; crc_a[1] = 1;
        run_seq("after_abort", 2, 0);

        // Asynchronous reset in the middle of block 2's decode
        sched_start = 1'b1;
        cb_last     = 3'd2;
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            sched_start = 1'b0;
            dec_end     = (t == 4) || (t == 9);
            dec_crc     = (t == 4);
        end
        chk("pre_rst.dec_run",  32'(dec_run), 1);
        chk("pre_rst.cb_idx",   32'(cb_idx), 2);
        chk("pre_rst.crc_map",  32'(crc_map), 32'h01);
        chk("pre_rst.fail_cnt", 32'(crc_fail_cnt), 1);
        dec_end = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("post_rst.busy",      32'(sched_busy), 0);
            chk("post_rst.dec_start", 32'(dec_start), 0);
            chk("post_rst.dec_run",   32'(dec_run), 0);
        end

        // Randomized transport blocks, occasionally hitting the watchdog edge
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int k = 0; k < 8; k++) begin
                dly_a[k] = $urandom_range(1, 12);
                crc_a[k] = 1'($urandom);
            end
            case ($urandom_range(0, 3))
                0:       dly_a[$urandom_range(0, n - 1)] = TC;
                1:       dly_a[$urandom_range(0, n - 1)] = TC + 1;
                default: ;
            endcase
            run_seq("random", n, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
